// File: rtl/rv32i_wb_arbiter.sv
// rtl/rv32i_wb_arbiter.sv - merges pipeline writeback and mul/div results onto one register-file write port
module rv32i_wb_arbiter #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_pipe_valid,
    input  logic [4:0]                 i_pipe_rd,
    input  logic [WIDTH-1:0]           i_pipe_data,
    output logic                       o_stall,
    input  logic                       i_md_valid,
    output logic                       o_md_ready,
    input  logic [4:0]                 i_md_rd,
    input  logic [WIDTH-1:0]           i_md_data,
    output logic                       o_we,
    output logic [4:0]                 o_rd_addr,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH):0]     o_fifo_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       r_fifo_rd   [DEPTH];
    logic [WIDTH-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;
    logic             r_stall;
    logic             r_we;
    logic [4:0]       r_rd_addr;
    logic [WIDTH-1:0] r_rd_data;

    logic             w_md_ready;
    logic             w_md_xfer;
    logic             w_fifo_empty;
    logic             w_pipe_win;
    logic             w_pop;
    logic             w_bypass;
    logic             w_push;
    logic [SW-1:0]    w_starve_next;
    logic [CW-1:0]    w_count_next;

    // Ready is combinational from occupancy so a full FIFO never accepts on its popping cycle
    assign w_md_ready   = (r_count < CW'(DEPTH));
    assign o_md_ready   = !rst && w_md_ready;
    assign w_md_xfer    = i_md_valid && o_md_ready;
    assign w_fifo_empty = (r_count == '0);

    // Slot arbitration: pipe first, then FIFO head, then a fresh mul/div result bypasses the FIFO
    always_comb begin
        w_pipe_win = i_pipe_valid && !r_stall && (i_pipe_rd != 5'd0);
        w_pop      = !w_pipe_win && !w_fifo_empty;
        w_bypass   = !w_pipe_win && w_fifo_empty && w_md_xfer && (i_md_rd != 5'd0);
        w_push     = w_md_xfer && (i_md_rd != 5'd0) && !w_bypass;
    end

    // Starvation counter counts pipe wins that left a buffered result waiting
    always_comb begin
        w_starve_next = r_starve;
        if (w_pop || w_fifo_empty) begin
            w_starve_next = '0;
        end else if (w_pipe_win && (r_starve != SW'(STARVE_LIMIT))) begin
            w_starve_next = r_starve + SW'(1);
        end
    end

    // Occupancy after this cycle's push and pop
    always_comb begin
        w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    end

    // FIFO storage; contents are don't-care until a pointer points at them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= i_md_rd;
            r_fifo_data[r_wr_ptr] <= i_md_data;
        end
    end

    // FIFO pointers, occupancy and the starvation guard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count  <= w_count_next;
            r_starve <= w_starve_next;
            r_stall  <= (w_starve_next == SW'(STARVE_LIMIT));
        end
    end

    // Registered write port; address and data hold when no slot is written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            r_we <= w_pipe_win || w_pop || w_bypass;
            if (w_pipe_win) begin
                r_rd_addr <= i_pipe_rd;
                r_rd_data <= i_pipe_data;
            end else if (w_pop) begin
                r_rd_addr <= r_fifo_rd[r_rd_ptr];
                r_rd_data <= r_fifo_data[r_rd_ptr];
            end else if (w_bypass) begin
                r_rd_addr <= i_md_rd;
                r_rd_data <= i_md_data;
            end
        end
    end

    assign o_stall      = r_stall;
    assign o_we         = r_we;
    assign o_rd_addr    = r_rd_addr;
    assign o_rd_data    = r_rd_data;
    assign o_fifo_count = r_count;

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// tb/tb_rv32i_wb_arbiter.sv - directed self-checking bench for rv32i_wb_arbiter
module tb_rv32i_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        i_pipe_valid;
    logic [4:0]  i_pipe_rd;
    logic [31:0] i_pipe_data;
    logic        o_stall;
    logic        i_md_valid;
    logic        o_md_ready;
    logic [4:0]  i_md_rd;
    logic [31:0] i_md_data;
    logic        o_we;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic [1:0]  o_fifo_count;

    int total;
    int bad;

    rv32i_wb_arbiter #(.WIDTH(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pipe_valid (i_pipe_valid),
        .i_pipe_rd    (i_pipe_rd),
        .i_pipe_data  (i_pipe_data),
        .o_stall      (o_stall),
        .i_md_valid   (i_md_valid),
        .o_md_ready   (o_md_ready),
        .i_md_rd      (i_md_rd),
        .i_md_data    (i_md_data),
        .o_we         (o_we),
        .o_rd_addr    (o_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_fifo_count (o_fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        i_pipe_valid = v;
        i_pipe_rd    = rd;
        i_pipe_data  = d;
    endtask

    task automatic md(input logic v, input logic [4:0] rd, input logic [31:0] d);
        i_md_valid = v;
        i_md_rd    = rd;
        i_md_data  = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        pipe(1'b0, 5'd0, 32'h0);
        md(1'b0, 5'd0, 32'h0);

        // reset state
        repeat (2) step();
        chk("rst_we", {31'b0, o_we}, 32'd0);
        chk("rst_addr", {27'b0, o_rd_addr}, 32'd0);
        chk("rst_data", o_rd_data, 32'd0);
        chk("rst_stall", {31'b0, o_stall}, 32'd0);
        chk("rst_ready", {31'b0, o_md_ready}, 32'd0);
        chk("rst_count", {30'b0, o_fifo_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", {31'b0, o_md_ready}, 32'd1);

        // pipe only
        pipe(1'b1, 5'd1, 32'hA5A5A5A5);
        step();
        chk("pipe_we", {31'b0, o_we}, 32'd1);
        chk("pipe_addr", {27'b0, o_rd_addr}, 32'd1);
        chk("pipe_data", o_rd_data, 32'hA5A5A5A5);
        pipe(1'b0, 5'd0, 32'h0);
        step();
        chk("idle_we", {31'b0, o_we}, 32'd0);
        chk("idle_hold_addr", {27'b0, o_rd_addr}, 32'd1);
        chk("idle_hold_data", o_rd_data, 32'hA5A5A5A5);

        // bypass
        md(1'b1, 5'd5, 32'h00000064);
        chk("byp_ready", {31'b0, o_md_ready}, 32'd1);
        step();
        md(1'b0, 5'd0, 32'h0);
        chk("byp_we", {31'b0, o_we}, 32'd1);
        chk("byp_addr", {27'b0, o_rd_addr}, 32'd5);
        chk("byp_data", o_rd_data, 32'h64);
        chk("byp_count", {30'b0, o_fifo_count}, 32'd0);

        // contention, fill and starvation guard
        pipe(1'b1, 5'd2, 32'h20);
        md(1'b1, 5'd7, 32'h70);
        step();
        chk("c1_addr", {27'b0, o_rd_addr}, 32'd2);
        chk("c1_count", {30'b0, o_fifo_count}, 32'd1);
        md(1'b1, 5'd8, 32'h80);
        step();
        md(1'b0, 5'd0, 32'h0);
        chk("c2_count", {30'b0, o_fifo_count}, 32'd2);
        chk("c2_ready", {31'b0, o_md_ready}, 32'd0);
        chk("c2_stall", {31'b0, o_stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("c_pipe_addr", {27'b0, o_rd_addr}, 32'd2);
            chk("c_stall", {31'b0, o_stall}, (i == 2) ? 32'd1 : 32'd0);
        end
        step();
        chk("s1_we", {31'b0, o_we}, 32'd1);
        chk("s1_addr", {27'b0, o_rd_addr}, 32'd7);
        chk("s1_data", o_rd_data, 32'h70);
        chk("s1_stall", {31'b0, o_stall}, 32'd0);
        chk("s1_count", {30'b0, o_fifo_count}, 32'd1);
        chk("s1_ready", {31'b0, o_md_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("c2_pipe_addr", {27'b0, o_rd_addr}, 32'd2);
            chk("c2_stall_seq", {31'b0, o_stall}, (i == 3) ? 32'd1 : 32'd0);
        end
        step();
        chk("s2_addr", {27'b0, o_rd_addr}, 32'd8);
        chk("s2_data", o_rd_data, 32'h80);
        chk("s2_count", {30'b0, o_fifo_count}, 32'd0);
        pipe(1'b0, 5'd0, 32'h0);
        step();

        // x0 drop from both sources
        pipe(1'b1, 5'd0, 32'h12345678);
        md(1'b1, 5'd0, 32'hFFFFFFFF);
        chk("x0_ready", {31'b0, o_md_ready}, 32'd1);
        step();
        pipe(1'b0, 5'd0, 32'h0);
        md(1'b0, 5'd0, 32'h0);
        chk("x0_we", {31'b0, o_we}, 32'd0);
        chk("x0_count", {30'b0, o_fifo_count}, 32'd0);

        // simultaneous push and pop
        pipe(1'b1, 5'd1, 32'h11);
        md(1'b1, 5'd3, 32'h33);
        step();
        chk("pp0_count", {30'b0, o_fifo_count}, 32'd1);
        pipe(1'b0, 5'd0, 32'h0);
        md(1'b1, 5'd4, 32'h44);
        step();
        md(1'b0, 5'd0, 32'h0);
        chk("pp1_addr", {27'b0, o_rd_addr}, 32'd3);
        chk("pp1_data", o_rd_data, 32'h33);
        chk("pp1_count", {30'b0, o_fifo_count}, 32'd1);
        step();
        chk("pp2_addr", {27'b0, o_rd_addr}, 32'd4);
        chk("pp2_data", o_rd_data, 32'h44);
        chk("pp2_count", {30'b0, o_fifo_count}, 32'd0);
        step();

        // reset mid-operation with two buffered entries and a write in flight
        pipe(1'b1, 5'd1, 32'h1);
        md(1'b1, 5'd9, 32'h99);
        step();
        md(1'b1, 5'd10, 32'hAA);
        step();
        pipe(1'b0, 5'd0, 32'h0);
        md(1'b0, 5'd0, 32'h0);
        chk("mr_count_pre", {30'b0, o_fifo_count}, 32'd2);
        chk("mr_we_pre", {31'b0, o_we}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_we", {31'b0, o_we}, 32'd0);
        chk("mr_count", {30'b0, o_fifo_count}, 32'd0);
        chk("mr_ready", {31'b0, o_md_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_rel_ready", {31'b0, o_md_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_no_stale_we", {31'b0, o_we}, 32'd0);
            chk("mr_post_count", {30'b0, o_fifo_count}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_wb_arbiter.md
Name: rv32i_wb_arbiter

Overview:
Write-side initiator for the rv32i_basereg register file. It merges two result sources onto the register file's single write port (we/rd_addr/rd_data):
- the in-order pipeline writeback stream, one result per cycle, no backpressure;
- the multi-cycle M-extension mul/div unit, with a valid/ready handshake.

Mul/div results are buffered in a small FIFO and drained into idle write slots. A starvation guard stalls the pipeline when a mul/div result has waited too long.

Parameters:
WIDTH, 32, data width of register values
DEPTH, 2, mul/div result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive lost slots with FIFO non-empty before a forced drain

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
i_pipe_valid  input  1  pipeline writeback result present
i_pipe_rd  input  5  pipeline destination register
i_pipe_data  input  WIDTH  pipeline result
o_stall  output  1  registered; pipeline input ignored this cycle, upstream holds i_pipe_* stable
i_md_valid  input  1  mul/div result present
o_md_ready  output  1  arbiter can accept mul/div result
i_md_rd  input  5  mul/div destination register
i_md_data  input  WIDTH  mul/div result
o_we  output  1  register file write enable (to i_we)
o_rd_addr  output  5  register file write address (to i_rd_addr)
o_rd_data  output  WIDTH  register file write data (to i_rd_data)
o_fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
Reset
- While rst=1: o_we=0, o_rd_addr=0, o_rd_data=0, o_stall=0, o_md_ready=0, FIFO empty, starve counter=0.
- Reset asserted mid-operation discards all buffered entries and any in-flight output write.

Handshake and latency
- o_md_ready = !rst && (count < DEPTH). A mul/div transfer occurs on the edge where i_md_valid && o_md_ready.
- Outputs are registered. A result accepted in cycle N appears on o_we/o_rd_addr/o_rd_data in cycle N+1 at the earliest, for exactly one cycle.

Slot arbitration (decided in cycle N, result visible in N+1)
- Pipe wins if: i_pipe_valid && !o_stall && i_pipe_rd!=0.
- Else, if FIFO non-empty: pop head and write it.
- Else, if a mul/div transfer with rd!=0 occurs this cycle: bypass it directly to the output without enqueueing.
- Else: o_we=0. o_rd_addr and o_rd_data hold their previous values.

Enqueue
- A mul/div transfer is enqueued if rd!=0 and it is not bypassed.
- Simultaneous push and pop are legal. Occupancy is unchanged and FIFO order is preserved.

x0 handling
- Writes to x0 from either source never produce o_we=1.
- A mul/div transfer with rd=0 completes the handshake and is dropped; no FIFO entry is used.
- A pipe result with rd=0 leaves the slot free for the FIFO.

Starvation guard
- The counter increments on each cycle where the FIFO is non-empty and the pipe wins.
- The counter clears on any FIFO pop, or when the FIFO is empty.
- When counter == STARVE_LIMIT, o_stall=1 next cycle. In that cycle:
  - the pipe input is ignored;
  - the FIFO head pops;
  - the counter clears.
- o_stall lasts exactly one cycle per trigger.

Full FIFO
- o_md_ready=0. Ready is not asserted on the same-cycle pop (no pass-through when full).
- Ready returns to 1 the cycle after count drops below DEPTH.

Ordering
- Mul/div results are written in acceptance order.
- WAW between sources is prevented upstream; the arbiter does not reorder or merge.

o_fifo_count is the registered occupancy, 0..DEPTH.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries, rst=1 asynchronously → o_we=0, o_fifo_count=0, o_md_ready=0 immediately; after release, o_md_ready=1 and no stale writes appear.
- Pipe only: i_pipe_valid=1, rd=1, data=32'hA5A5A5A5 in cycle N → cycle N+1: o_we=1, o_rd_addr=1, o_rd_data=A5A5A5A5; a following read of x1 from rv32i_basereg returns A5A5A5A5.
- Bypass: pipe idle, FIFO empty, md transfer rd=5, data=32'h0000_0064 → next cycle o_we=1, o_rd_addr=5, o_rd_data=0x64; o_fifo_count stays 0.
- Contention and fill: pipe valid every cycle with rd=2, two md transfers (rd=7 then rd=8) → o_fifo_count=2, o_md_ready=0.
  - After 4 pipe wins: o_stall=1 for one cycle; that cycle's output slot is x7.
  - Repeat → x8.
  - Order is x7 then x8.
- x0 drop: md transfer rd=0, data=FFFFFFFF and pipe rd=0 in the same cycle → handshake completes, o_we=0 next cycle, o_fifo_count=0.
- Simultaneous push/pop: FIFO=1 entry (rd=3), pipe idle, md transfer rd=4 → next cycle writes x3, count stays 1; the cycle after writes x4, count=0.
